// File: rtl/data_ram_pkg.sv
// Shared definitions for the word-organised data memory.
package data_ram_pkg;

    // Default word-address width (1024 words, 4 KiB).
    localparam int unsigned DATA_MEM_NUM_LOG2 = 10;

    // Bus geometry.
    localparam int unsigned REG_BUS_W = 32;
    localparam int unsigned NUM_LANES = 4;

    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

    // Control-level encodings on the core's memory port.
    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

    // Clear-engine / access FSM.
    typedef enum logic {
        DRAM_CLEAR = 1'b0,
        DRAM_READY = 1'b1
    } dram_state_e;

endpackage

// File: rtl/data_ram.sv
// Data memory for the core's ram_* load/store port: combinational word read,
// byte-lane masked write, and a post-reset sequential clear engine.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_W     = DATA_MEM_NUM_LOG2,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 we,
    input  logic [31:0]          addr,
    input  logic [NUM_LANES-1:0] sel,
    input  logic [31:0]          data_i,
    output logic [31:0]          data_o,
    output logic                 init_busy,
    output logic                 addr_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    logic [REG_BUS_W-1:0] mem [0:DEPTH-1];

    dram_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              init_busy_q, init_busy_d;
    logic              addr_err_q, addr_err_d;

    logic [ADDR_W-1:0]    idx;
    logic                 out_of_range;
    logic                 clr_en;
    logic                 wr_en;
    logic [REG_BUS_W-1:0] wr_word;
    logic                 unused_addr_lsb;

    // Byte offset is carried in sel, so the low address bits play no part.
    assign idx             = addr[ADDR_W+1:2];
    assign out_of_range    = |addr[31:ADDR_W+2];
    assign unused_addr_lsb = ^addr[1:0];

    // Array updates are suppressed while reset is held so a restart always begins from index 0.
    assign clr_en = (rst != RST_ENABLE) && (state_q == DRAM_CLEAR);
    assign wr_en  = (rst != RST_ENABLE) && (state_q == DRAM_READY) &&
                    (ce == CHIP_ENABLE) && (we == WRITE_ENABLE) &&
                    !out_of_range && (|sel);

    // Lane merge: selected bytes from store data, others from the current word.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign wr_word[8*i +: 8] = sel[i] ? data_i[8*i +: 8] : mem[idx][8*i +: 8];
    end

    // Next-state logic for the clear engine, busy flag and sticky address error.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        init_busy_d = init_busy_q;
        addr_err_d  = addr_err_q;
        if (rst == RST_ENABLE) begin
            state_d     = INIT_CLEAR ? DRAM_CLEAR : DRAM_READY;
            clr_idx_d   = '0;
            init_busy_d = INIT_CLEAR;
            addr_err_d  = 1'b0;
        end else begin
            case (state_q)
                DRAM_CLEAR: begin
                    clr_idx_d = clr_idx_q + 1'b1;
                    if (clr_idx_q == LAST_IDX) begin
                        state_d     = DRAM_READY;
                        init_busy_d = 1'b0;
                    end
                end
                DRAM_READY: begin
                    if ((ce == CHIP_ENABLE) && out_of_range) begin
                        addr_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = DRAM_READY;
                end
            endcase
        end
    end

    // Control state registers (reset handled in the next-state logic).
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        clr_idx_q   <= clr_idx_d;
        init_busy_q <= init_busy_d;
        addr_err_q  <= addr_err_d;
    end

    // Array write port: clear engine has priority, otherwise a masked store.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx_q] <= ZERO_WORD;
        end else if (wr_en) begin
            mem[idx] <= wr_word;
        end
    end

    // Combinational load path; returns the pre-edge word when written in the same cycle.
    always_comb begin
        data_o = ZERO_WORD;
        if ((ce == CHIP_ENABLE) && !init_busy_q && !out_of_range) begin
            data_o = mem[idx];
        end
    end

    assign init_busy = init_busy_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: clear engine timing, masked stores, range errors,
// reset restart during clear, same-cycle read/write ordering.
module tb_data_ram;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;

    logic [31:0] d1_data;
    logic        d1_busy;
    logic        d1_err;
    logic [31:0] d2_data;
    logic        d2_busy;
    logic        d2_err;

    int checks   = 0;
    int failures = 0;

    data_ram #(.ADDR_W(4), .INIT_CLEAR(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .we        (we),
        .addr      (addr),
        .sel       (sel),
        .data_i    (data_i),
        .data_o    (d1_data),
        .init_busy (d1_busy),
        .addr_err  (d1_err)
    );

    data_ram #(.ADDR_W(4), .INIT_CLEAR(1'b0)) dut_noclr (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .we        (we),
        .addr      (addr),
        .sel       (sel),
        .data_i    (data_i),
        .data_o    (d2_data),
        .init_busy (d2_busy),
        .addr_err  (d2_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic c, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        ce = c; we = w; addr = a; sel = s; data_i = d;
    endtask

    int n;

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // ---- 1: reset state and clear duration
        tick();
        rst = 1'b0;
        #1;
        chk("rst_busy1", {31'b0, d1_busy}, 32'd1);
        chk("rst_busy2", {31'b0, d2_busy}, 32'd0);
        chk("rst_err1", {31'b0, d1_err}, 32'd0);
        chk("rst_data_ce0", d1_data, 32'h0);
        drive(1'b1, 1'b0, 32'h3C, 4'hF, 32'h0);
        #1;
        chk("busy_read_zero", d1_data, 32'h0);
        n = 0;
        while (d1_busy === 1'b1 && n < 100) begin
            n++;
            tick();
            #1;
        end
        chk("clear_cycles", n, 32'd16);
        drive(1'b1, 1'b0, 32'h24, 4'hF, 32'h0);
        #1;
        chk("post_clear_lw", d1_data, 32'h0);

        // ---- 2: full word store
        tick();
        drive(1'b1, 1'b1, 32'h8, 4'hF, 32'hDEADBEEF);
        tick();
        we = 1'b0;
        #1;
        chk("sw_full", d1_data, 32'hDEADBEEF);

        // ---- 3: byte, half and empty-mask stores
        tick();
        drive(1'b1, 1'b1, 32'h9, 4'b0100, 32'h00AA0000);
        tick();
        drive(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
        #1;
        chk("sb_lane2", d1_data, 32'hDEAABEEF);
        tick();
        drive(1'b1, 1'b1, 32'h8, 4'b0011, 32'h00001234);
        tick();
        we = 1'b0;
        #1;
        chk("sh_low", d1_data, 32'hDEAA1234);
        tick();
        drive(1'b1, 1'b1, 32'h8, 4'b0000, 32'hFFFFFFFF);
        tick();
        we = 1'b0;
        #1;
        chk("sel0_nowrite", d1_data, 32'hDEAA1234);

        // ---- 6: same-cycle write/read returns old word
        tick();
        drive(1'b1, 1'b1, 32'h4, 4'hF, 32'h11111111);
        tick();
        drive(1'b1, 1'b1, 32'h4, 4'hF, 32'h22222222);
        #1;
        chk("rw_same_old", d1_data, 32'h11111111);
        tick();
        we = 1'b0;
        #1;
        chk("rw_next_new", d1_data, 32'h22222222);
        ce = 1'b0;
        #1;
        chk("ce0_zero", d1_data, 32'h0);

        // ---- 4: last in-range word, then out-of-range access
        tick();
        drive(1'b1, 1'b1, 32'h3C, 4'hF, 32'hA5A5A5A5);
        tick();
        we = 1'b0;
        #1;
        chk("last_word", d1_data, 32'hA5A5A5A5);
        chk("last_word_noerr", {31'b0, d1_err}, 32'd0);
        tick();
        drive(1'b1, 1'b1, 32'h40, 4'hF, 32'h55555555);
        #1;
        chk("oor_data_zero", d1_data, 32'h0);
        chk("oor_err_not_yet", {31'b0, d1_err}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        #1;
        chk("oor_err_set", {31'b0, d1_err}, 32'd1);
        chk("oor_no_alias_write", d1_data, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h4, 4'hF, 32'h33333333);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("oor_err_sticky", {31'b0, d1_err}, 32'd1);

        // ---- 5: prefill, restart clear mid-way, writes during clear ignored
        for (int i = 0; i < 16; i++) begin
            tick();
            drive(1'b1, 1'b1, i * 4, 4'hF, 32'h10000000 + i);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_clears_err", {31'b0, d1_err}, 32'd0);
        chk("rst_busy_again", {31'b0, d1_busy}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n = 0;
        while (d1_busy === 1'b1 && n < 100) begin
            n++;
            if (n == 10) drive(1'b1, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
            else if (n == 11) drive(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
            else drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            tick();
            #1;
        end
        chk("restart_cycles", n, 32'd16);
        chk("clear_access_noerr", {31'b0, d1_err}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, i * 4, 4'hF, 32'h0);
            #1;
            chk($sformatf("cleared_w%0d", i), d1_data, 32'h0);
            chk($sformatf("kept_w%0d", i), d2_data,
                (i == 0) ? 32'hCAFEF00D : 32'h10000000 + i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
